// File: rtl/phy_mem_ctrl_pkg.sv
// Shared definitions for the physical memory controller: FSM state encodings,
// default SRAM geometry and wait states, and the request tuple type.
package phy_mem_ctrl_pkg;

  localparam int PHY_MEM_ST_WIDTH          = 3;
  localparam int PHY_MEM_DEF_SRAM_ADDR_W   = 20;
  localparam int PHY_MEM_DEF_READ_WAIT     = 2;
  localparam int PHY_MEM_DEF_WRITE_WAIT    = 2;

  typedef enum logic [PHY_MEM_ST_WIDTH-1:0] {
    PHY_MEM_ST_IDLE     = 3'd0,
    PHY_MEM_ST_RD       = 3'd1,
    PHY_MEM_ST_WR_SETUP = 3'd2,
    PHY_MEM_ST_WR_PULSE = 3'd3,
    PHY_MEM_ST_WR_HOLD  = 3'd4,
    PHY_MEM_ST_TURN     = 3'd5
  } phy_mem_st_e;

  // Request identity: word address, direction and write data (addr[1:0] excluded).
  typedef struct packed {
    logic [29:0] word;
    logic        is_write;
    logic [31:0] data;
  } phy_mem_req_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phy_mem_req_detect.sv
// Remembers the last accepted request tuple and flags a request as new when it
// differs from it (or nothing has been accepted since reset); also range-checks it.
module phy_mem_req_detect
  import phy_mem_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = PHY_MEM_DEF_SRAM_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  phy_mem_req_t req,
  input  logic         idle,
  output logic         new_req,
  output logic         out_of_range
);

  phy_mem_req_t last_q, last_d;
  logic         last_valid_q, last_valid_d;

  assign out_of_range = (req.word >> SRAM_ADDR_WIDTH) != '0;

  // Gated by rst so busy/err stay low while reset is held.
  always_comb begin
    new_req      = rst && idle && (!last_valid_q || (req != last_q));
    last_d       = last_q;
    last_valid_d = last_valid_q;
    if (new_req) begin
      last_d       = req;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end

endmodule

// File: rtl/phy_mem_ctrl.sv
// CPU physical memory port responder driving one async 32-bit SRAM with programmable
// wait states. Define PHY_MEM_TURNAROUND_EN to insert a bus turnaround cycle on read/write switches.
module phy_mem_ctrl
  import phy_mem_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = PHY_MEM_DEF_SRAM_ADDR_W,
  parameter int READ_WAIT       = PHY_MEM_DEF_READ_WAIT,
  parameter int WRITE_WAIT      = PHY_MEM_DEF_WRITE_WAIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                dev_mem_addr,
  input  logic [31:0]                dev_mem_data_out,
  input  logic                       dev_mem_is_write,
  output logic [31:0]                dev_mem_data_in,
  output logic                       dev_mem_busy,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]                sram_data_out,
  output logic                       sram_data_oe,
  input  logic [31:0]                sram_data_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       err_addr
);

  localparam int CW = $clog2(max2(READ_WAIT, WRITE_WAIT)) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WRITE_WAIT - 1);

  phy_mem_st_e                state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                       data_oe_q, data_oe_d;
`ifdef PHY_MEM_TURNAROUND_EN
  logic                       prev_vld_q, prev_vld_d, prev_wr_q, prev_wr_d;
`endif

  phy_mem_req_t req;
  logic         new_req, out_of_range;
  logic         addr_lo_unused;

  assign req            = '{word: dev_mem_addr[31:2], is_write: dev_mem_is_write,
                            data: dev_mem_data_out};
  assign addr_lo_unused = ^dev_mem_addr[1:0];

  phy_mem_req_detect #(.SRAM_ADDR_WIDTH(SRAM_ADDR_WIDTH)) u_req_detect (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .idle         (state_q == PHY_MEM_ST_IDLE),
    .new_req      (new_req),
    .out_of_range (out_of_range)
  );

  assign dev_mem_busy    = new_req || (state_q != PHY_MEM_ST_IDLE);
  assign err_addr        = new_req && out_of_range;
  assign dev_mem_data_in = rdata_q;
  assign sram_addr       = addr_q;
  assign sram_data_out   = wdata_q;
  assign sram_data_oe    = data_oe_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef PHY_MEM_TURNAROUND_EN
    prev_vld_d = prev_vld_q;
    prev_wr_d  = prev_wr_q;
`endif
    case (state_q)
      PHY_MEM_ST_IDLE: begin
        if (new_req) begin
          if (out_of_range) begin
            if (!dev_mem_is_write) rdata_d = '0;
          end else begin
            addr_d  = dev_mem_addr[SRAM_ADDR_WIDTH+1:2];
            wdata_d = dev_mem_data_out;
            cnt_d   = '0;
            state_d = dev_mem_is_write ? PHY_MEM_ST_WR_SETUP : PHY_MEM_ST_RD;
`ifdef PHY_MEM_TURNAROUND_EN
            if (prev_vld_q && (prev_wr_q != dev_mem_is_write)) state_d = PHY_MEM_ST_TURN;
            prev_vld_d = 1'b1;
            prev_wr_d  = dev_mem_is_write;
`endif
          end
        end
      end
      PHY_MEM_ST_RD: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = sram_data_in;
          state_d = PHY_MEM_ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PHY_MEM_ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = PHY_MEM_ST_WR_PULSE;
      end
      PHY_MEM_ST_WR_PULSE: begin
        if (cnt_q == WR_LAST) state_d = PHY_MEM_ST_WR_HOLD;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      PHY_MEM_ST_WR_HOLD: state_d = PHY_MEM_ST_IDLE;
`ifdef PHY_MEM_TURNAROUND_EN
      // prev_wr_q already holds the direction of the access waiting behind TURN.
      PHY_MEM_ST_TURN: state_d = prev_wr_q ? PHY_MEM_ST_WR_SETUP : PHY_MEM_ST_RD;
`endif
      default: state_d = PHY_MEM_ST_IDLE;
    endcase

    // Strobes are registered off the next state so the pads see clean edges.
    ce_n_d    = !(state_d inside {PHY_MEM_ST_RD, PHY_MEM_ST_WR_SETUP,
                                  PHY_MEM_ST_WR_PULSE, PHY_MEM_ST_WR_HOLD});
    oe_n_d    = (state_d != PHY_MEM_ST_RD);
    we_n_d    = (state_d != PHY_MEM_ST_WR_PULSE);
    data_oe_d = state_d inside {PHY_MEM_ST_WR_SETUP, PHY_MEM_ST_WR_PULSE, PHY_MEM_ST_WR_HOLD};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PHY_MEM_ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      data_oe_q <= data_oe_d;
    end
  end

`ifdef PHY_MEM_TURNAROUND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_vld_q <= 1'b0;
      prev_wr_q  <= 1'b0;
    end else begin
      prev_vld_q <= prev_vld_d;
      prev_wr_q  <= prev_wr_d;
    end
  end
`endif

endmodule
